mul_div_32: RTL

- Iterative 32-bit multiply/divide unit for the CPU execute stage. Handles signed and unsigned MUL and DIV.
- Produces a 64-bit product, or a quotient/remainder pair, in hi/lo registers.
- lo feeds the downstream 32-bit zero-detect that sets the ALU zero flag.
- Uses a start/busy/done handshake with the pipeline controller.

---
 rtl/mul_div_32_pkg.sv | 18 +
 rtl/mul_div_32.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/mul_div_32_pkg.sv
// Shared encodings for the iterative multiply/divide unit.
// Operation codes match the 2-bit op field driven by the execute stage.
package mul_div_32_pkg;

    typedef enum logic [1:0] {
        OP_MULTU = 2'b00,
        OP_MULT  = 2'b01,
        OP_DIVU  = 2'b10,
        OP_DIV   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_e;

endpackage

// File: rtl/mul_div_32.sv
// Iterative signed/unsigned multiply and divide, one bit per clock.
// Results land in hi/lo after a sign-fix cycle; divide-by-zero finishes at once.
module mul_div_32
    import mul_div_32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             dz,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_e               r_state;
    op_e                  r_op;
    logic                 r_neg_q;
    logic                 r_neg_r;
    logic [CNT_W-1:0]     r_cnt;
    logic [2*WIDTH-1:0]   r_acc;
    logic [2*WIDTH-1:0]   r_x;
    logic [WIDTH-1:0]     r_y;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_dz;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    logic                 w_sgn;
    logic [WIDTH-1:0]     w_abs_a;
    logic [WIDTH-1:0]     w_abs_b;
    logic                 w_run_div;
    logic [2*WIDTH-1:0]   w_sh;
    logic [WIDTH:0]       w_diff;
    logic [2*WIDTH-1:0]   w_acc_nxt;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_q;
    logic [WIDTH-1:0]     w_r;

    assign w_sgn   = op[0];
    assign w_abs_a = (w_sgn && a[WIDTH-1]) ? -a : a;
    assign w_abs_b = (w_sgn && b[WIDTH-1]) ? -b : b;

    assign w_run_div = (r_op == OP_DIVU) || (r_op == OP_DIV);

    // Divide keeps {remainder, quotient} in one register; quotient bits
    // shift in from the right as the dividend bits shift out the top.
    assign w_sh   = {r_acc[2*WIDTH-2:0], 1'b0};
    assign w_diff = {1'b0, w_sh[2*WIDTH-1:WIDTH]} - {1'b0, r_y};

    always_comb begin
        w_acc_nxt = r_acc;
        if (w_run_div) begin
            if (!w_diff[WIDTH])
                w_acc_nxt = {w_diff[WIDTH-1:0], w_sh[WIDTH-1:1], 1'b1};
            else
                w_acc_nxt = w_sh;
        end else if (r_y[0]) begin
            w_acc_nxt = r_acc + r_x;
        end
    end

    assign w_prod = r_neg_q ? -r_acc : r_acc;
    assign w_q    = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
    assign w_r    = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH]
                            : r_acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_op    <= OP_MULTU;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_x     <= '0;
            r_y     <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_dz    <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (op[1] && (b == '0)) begin
                            r_hi   <= a;
                            r_lo   <= '1;
                            r_dz   <= 1'b1;
                            r_done <= 1'b1;
                        end else begin
                            r_op    <= op_e'(op);
                            r_neg_q <= w_sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_neg_r <= w_sgn & a[WIDTH-1];
                            r_x     <= {{WIDTH{1'b0}}, w_abs_a};
                            r_y     <= w_abs_b;
                            r_acc   <= op[1] ? {{WIDTH{1'b0}}, w_abs_a}
                                             : '0;
                            r_cnt   <= '0;
                            r_busy  <= 1'b1;
                            r_state <= S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_x   <= r_x << 1;
                    r_y   <= w_run_div ? r_y : (r_y >> 1);
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH-1))
                        r_state <= S_FIX;
                end
                S_FIX: begin
                    if (w_run_div) begin
                        r_hi <= w_r;
                        r_lo <= w_q;
                    end else begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end
                    r_dz    <= 1'b0;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign dz   = r_dz;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
